// File: rtl/ll_cmd_seq.sv
// ----------------------------------------------------------------------------
// ll_cmd_seq
//
// Scripted command player for the linked_list block. A small script memory
// holds DEPTH entries of {cmd[2:0], data[7:0]}. On start, the entries are
// replayed one by one onto the linked_list switch bus. Each entry follows the
// same cadence:
//   FETCH (1 cycle)            sw_out = 0
//   SETUP (SETUP_CYCLES)       sw_out = {000, 5'b0, data}
//   HOLD  (HOLD_CYCLES)        sw_out = {cmd, 5'b0, data}
//   GAP   (GAP_CYCLES)         sw_out = {000, 5'b0, data}
// A cmd of 000 marks the end of the script. Rising edges on the overflow and
// underflow flags coming back from linked_list are counted (saturating).
//
// Configuration macro:
//   LL_SEQ_LOOP_EN - when defined, the end marker or the end of the last
//                    entry wraps back to entry 0 instead of going to DONE.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            level-sampled; starts playback from entry 0 (IDLE/DONE)
//   abort            return to IDLE on the next edge; counters and ptr held
//   load_we          script write strobe (accepted only in IDLE/DONE)
//   load_addr        script write address
//   load_data        script write data {cmd[2:0], data[7:0]}
//   flags            [0] overflow, [1] underflow from linked_list.led
//   sw_out           {cmd[2:0], 5'b0, data[7:0]} to linked_list.sw
//   busy             high in FETCH, SETUP, HOLD, GAP
//   done             high in DONE
//   ptr              address of the entry being played
//   ovf_cnt, udf_cnt saturating rising-edge counts of flags[0] / flags[1]
// ----------------------------------------------------------------------------
module ll_cmd_seq #(
  parameter int DEPTH        = 16,
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 10,
  parameter int GAP_CYCLES   = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [10:0]              load_data,
  input  logic [1:0]               flags,
  output logic [15:0]              sw_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] ptr,
  output logic [7:0]               ovf_cnt,
  output logic [7:0]               udf_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_SH > GAP_CYCLES) ? MAX_SH : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // The down-counter is loaded with N-1 on state entry and the state ends
  // when it reaches zero, giving exactly N cycles in the state.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [AW-1:0]   ptr_q,   ptr_d;
  logic [10:0]     entry_q, entry_d;
  logic [1:0]      flags_q;
  logic [7:0]      ovf_q,   ovf_d;
  logic [7:0]      udf_q,   udf_d;

  logic [10:0]     mem [DEPTH];
  logic [10:0]     rd_q;

  logic            idle_like;
  logic            wr_en;
  logic [1:0]      flag_rise;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_en     = load_we && idle_like && !abort;
  assign flag_rise = flags & ~flags_q;

  // --------------------------------------------------------------------------
  // Script memory. The read address is the *next* ptr, so the registered read
  // data is valid throughout the FETCH cycle. A write to the address being
  // read is forwarded so that load_we + start in one cycle plays the new word.
  // NOTE: the memory array and its read register carry no reset; a reset on
  // a RAM array prevents block-RAM inference and buys nothing, since every
  // location is written before it is meaningful.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_addr] <= load_data;
    end
    rd_q <= (wr_en && (load_addr == ptr_d)) ? load_data : mem[ptr_d];
  end

  // --------------------------------------------------------------------------
  // State registers.
  // NOTE: sequential state is always updated with non-blocking (<=)
  // assignments so every flop samples the pre-edge values; combinational
  // blocks use blocking (=) assignments.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      entry_q <= '0;
      flags_q <= '0;
      ovf_q   <= '0;
      udf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      entry_q <= entry_d;
      flags_q <= flags;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    entry_d = entry_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    // Flag rises count in every state except IDLE, saturating at 255.
    if (state_q != S_IDLE) begin
      if (flag_rise[0] && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
      if (flag_rise[1] && (udf_q != 8'hFF)) udf_d = udf_q + 8'd1;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_FETCH;
            ptr_d   = '0;
            ovf_d   = '0;
            udf_d   = '0;
          end
        end

        S_FETCH: begin
          if (rd_q[10:8] == 3'b000) begin
`ifdef LL_SEQ_LOOP_EN
            state_d = S_FETCH;
            ptr_d   = '0;
`else
            state_d = S_DONE;
`endif
          end else begin
            entry_d = rd_q;
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end
        end

        S_SETUP: begin
          if (cnt_q == '0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_GAP: begin
          if (cnt_q == '0) begin
            if (ptr_q == LAST_PTR) begin
`ifdef LL_SEQ_LOOP_EN
              state_d = S_FETCH;
              ptr_d   = '0;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_FETCH;
              ptr_d   = ptr_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (Moore, decoded from the state register).
  // --------------------------------------------------------------------------
  always_comb begin
    sw_out = 16'h0000;
    unique case (state_q)
      S_SETUP, S_GAP: sw_out = {3'b000, 5'b0, entry_q[7:0]};
      S_HOLD:         sw_out = {entry_q[10:8], 5'b0, entry_q[7:0]};
      default:        sw_out = 16'h0000;
    endcase
  end

  assign busy    = (state_q == S_FETCH) || (state_q == S_SETUP) ||
                   (state_q == S_HOLD)  || (state_q == S_GAP);
  assign done    = (state_q == S_DONE);
  assign ptr     = ptr_q;
  assign ovf_cnt = ovf_q;
  assign udf_cnt = udf_q;

endmodule

// File: tb/tb_ll_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_ll_cmd_seq
//
// Directed bench for ll_cmd_seq with default parameters. A behavioural model
// expands the bench's copy of the script into the per-cycle stream of
// (sw_out, busy, done, ptr) the player must produce; a compare process checks
// the DUT against that stream on every falling edge. Literal expectations at
// chosen cycles pin the model. Inputs change 1 time unit after rising edges.
// ----------------------------------------------------------------------------
module tb_ll_cmd_seq;

  localparam int DEPTH = 16;
  localparam int SETUP = 4;
  localparam int HOLD  = 10;
  localparam int GAP   = 20;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [10:0] load_data;
  logic [1:0]  flags;
  logic [15:0] sw_out;
  logic        busy;
  logic        done;
  logic [3:0]  ptr;
  logic [7:0]  ovf_cnt;
  logic [7:0]  udf_cnt;

  ll_cmd_seq #(
    .DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .flags(flags), .sw_out(sw_out), .busy(busy), .done(done), .ptr(ptr),
    .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [15:0] sw;
    logic        busy;
    logic        done;
    logic [3:0]  ptr;
  } exp_t;

  logic [10:0] script [DEPTH];
  exp_t        exp_q [$];

  function automatic void push(input logic [15:0] sw, input logic b, input logic d, input int p);
    exp_t e;
    e.sw = sw; e.busy = b; e.done = d; e.ptr = 4'(p);
    exp_q.push_back(e);
  endfunction

  // Expected output stream, one element per cycle, starting with the cycle
  // right after the start edge.
  function automatic void build_stream();
    int         i;
    bit         fin;
    bit         wrapped;
    bit         at_end;
    logic [2:0] cmd;
    logic [7:0] dat;
    exp_q.delete();
    i = 0; fin = 0; wrapped = 0;
    while (!fin && exp_q.size() < 4000) begin
      cmd = script[i][10:8];
      dat = script[i][7:0];
      push(16'h0000, 1'b1, 1'b0, i);
      if (cmd != 3'b000) begin
        repeat (SETUP) push({3'b000, 5'b0, dat}, 1'b1, 1'b0, i);
        repeat (HOLD)  push({cmd,    5'b0, dat}, 1'b1, 1'b0, i);
        repeat (GAP)   push({3'b000, 5'b0, dat}, 1'b1, 1'b0, i);
      end
      at_end = (cmd == 3'b000) || (i == DEPTH - 1);
`ifdef LL_SEQ_LOOP_EN
      if (wrapped) fin = 1;
      if (at_end) begin i = 0; wrapped = 1; end
      else i++;
`else
      if (at_end) begin
        fin = 1;
        repeat (3) push(16'h0000, 1'b0, 1'b1, i);
      end else begin
        i++;
      end
`endif
    end
  endfunction

  // Compare process: every falling edge while the model has expectations.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("stream", {10'b0, sw_out, busy, done, ptr}, {10'b0, e});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [10:0] d);
    @(posedge clk); #1;
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
    script[a] = d;
  endtask

  // Raises start (optionally with a same-cycle write), and returns 1 time unit
  // after the edge that samples it, with the expected stream built.
  task automatic start_play(input bit with_load, input logic [3:0] a, input logic [10:0] d);
    @(posedge clk); #1;
    start = 1'b1;
    if (with_load) begin
      load_we = 1'b1; load_addr = a; load_data = d;
      script[a] = d;
    end
    @(posedge clk);
    build_stream();
    #1;
    start = 1'b0; load_we = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic abort_now();
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    abort = 1'b0;
  endtask

  task automatic finish_run(input int budget);
    wait_drain(budget);
`ifdef LL_SEQ_LOOP_EN
    abort_now();
`endif
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int hi;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_we = 1'b0;
    load_addr = '0; load_data = '0; flags = 2'b00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sw",   {16'b0, sw_out}, 32'h0);
    check("rst_busy", {31'b0, busy},   32'h0);
    check("rst_done", {31'b0, done},   32'h0);
    check("rst_ptr",  {28'b0, ptr},    32'h0);
    check("rst_ovf",  {24'b0, ovf_cnt}, 32'h0);
    check("rst_udf",  {24'b0, udf_cnt}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) load(4'(i), 11'h000);

    // Test 1: four-entry script, basic cadence.
    load(4'd0, 11'h401);
    load(4'd1, 11'h403);
    load(4'd2, 11'h507);
    load(4'd3, 11'h50F);
    load(4'd4, 11'h000);
    start_play(1'b0, 4'd0, 11'h000);
`ifndef LL_SEQ_LOOP_EN
    n = 0; hi = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (sw_out[15:13] != 3'b000) hi++;
      if (n == 1)  check("t1_setup_data", {16'b0, sw_out}, 32'h0001);
      if (n == 5)  check("t1_first_cmd",  {16'b0, sw_out}, 32'h8001);
      if (n == 15) check("t1_gap_data",   {16'b0, sw_out}, 32'h0001);
      if (n == 75) check("t1_third_cmd",  {16'b0, sw_out}, 32'hA007);
    end
    check("t1_done_latency", 32'(n), 32'd141);
    check("t1_pulse_cycles", 32'(hi), 32'd40);
`endif
    finish_run(400);

    // Test 2: fifth insert overflows a 4-node list -> one flags[0] rise.
    load(4'd4, 11'h42F);
    load(4'd5, 11'h000);
    start_play(1'b0, 4'd0, 11'h000);
    wait_cycles(150);
    check("t2_fifth_cmd", {16'b0, sw_out}, 32'h802F);
    flags[0] = 1'b1;
    wait_cycles(3);
    flags[0] = 1'b0;
    finish_run(400);
    check("t2_ovf", {24'b0, ovf_cnt}, 32'd1);
    check("t2_udf", {24'b0, udf_cnt}, 32'd0);

    // Reset mid-GAP of entry 1.
    start_play(1'b0, 4'd0, 11'h000);
    wait_cycles(10);
    flags[0] = 1'b1;
    wait_cycles(1);
    flags[0] = 1'b0;
    wait_cycles(49);
    check("r_pre_ptr", {28'b0, ptr},     32'd1);
    check("r_pre_sw",  {16'b0, sw_out},  32'h0003);
    check("r_pre_ovf", {24'b0, ovf_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("r_sw",   {16'b0, sw_out},  32'h0);
    check("r_busy", {31'b0, busy},    32'h0);
    check("r_ptr",  {28'b0, ptr},     32'h0);
    check("r_ovf",  {24'b0, ovf_cnt}, 32'h0);
    check("r_udf",  {24'b0, udf_cnt}, 32'h0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(50);
    check("r_post_busy", {31'b0, busy},   32'h0);
    check("r_post_sw",   {16'b0, sw_out}, 32'h0);

    // Test 3: five deletes on an empty list, flags[1] pulsed on each.
    for (int i = 0; i < 5; i++) load(4'(i), {3'b110, 8'(8'h11 + i)});
    load(4'd5, 11'h000);
    start_play(1'b0, 4'd0, 11'h000);
    wait_cycles(8);
    for (int k = 0; k < 5; k++) begin
      flags[1] = 1'b1;
      wait_cycles(1);
      flags[1] = 1'b0;
      wait_cycles(34);
    end
    finish_run(400);
    check("t3_udf", {24'b0, udf_cnt}, 32'd5);
    check("t3_ovf", {24'b0, ovf_cnt}, 32'd0);

    // Saturation: 300 more rises.
`ifdef LL_SEQ_LOOP_EN
    start_play(1'b0, 4'd0, 11'h000);
    exp_q.delete();
`endif
    for (int k = 0; k < 300; k++) begin
      flags[1] = 1'b1;
      wait_cycles(1);
      flags[1] = 1'b0;
      wait_cycles(1);
    end
    check("sat_udf", {24'b0, udf_cnt}, 32'd255);
`ifdef LL_SEQ_LOOP_EN
    abort_now();
`endif

    // Test 4: abort during HOLD of entry 2; write while busy ignored.
    load(4'd0, 11'h401);
    load(4'd1, 11'h403);
    load(4'd2, 11'h507);
    load(4'd3, 11'h50F);
    load(4'd4, 11'h000);
    start_play(1'b0, 4'd0, 11'h000);
    wait_cycles(72);
    load_we = 1'b1; load_addr = 4'd0; load_data = 11'h4AA;
    wait_cycles(1);
    load_we = 1'b0;
    wait_cycles(7);
    check("a_hold_sw",  {16'b0, sw_out}, 32'hA007);
    check("a_hold_ptr", {28'b0, ptr},    32'd2);
    abort_now();
    check("a_sw",   {16'b0, sw_out}, 32'h0);
    check("a_busy", {31'b0, busy},   32'h0);
    check("a_done", {31'b0, done},   32'h0);
    check("a_ptr",  {28'b0, ptr},    32'd2);
    start_play(1'b0, 4'd0, 11'h000);
    wait_cycles(1);
    check("a_mem_kept", {16'b0, sw_out}, 32'h0001);
    finish_run(400);

    // Test 5: load_we and start in the same cycle.
    start_play(1'b1, 4'd0, 11'h555);
    wait_cycles(1);
    check("ls_setup", {16'b0, sw_out}, 32'h0055);
    wait_cycles(4);
    check("ls_cmd",   {16'b0, sw_out}, 32'hA055);
    finish_run(400);

    // Test 6: full 16-entry script with no end marker.
    for (int i = 0; i < DEPTH; i++) load(4'(i), {3'(3'b100 + i % 4), 8'(i * 3 + 1)});
    start_play(1'b0, 4'd0, 11'h000);
    wait_drain(800);
`ifdef LL_SEQ_LOOP_EN
    check("f_wrap_ptr",  {28'b0, ptr},  32'd1);
    check("f_wrap_busy", {31'b0, busy}, 32'd1);
    abort_now();
`else
    check("f_done", {31'b0, done}, 32'd1);
    check("f_ptr",  {28'b0, ptr},  32'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ll_cmd_seq.md
# ll_cmd_seq

Scripted command player for the `linked_list` block: it replays a loadable sequence of 11-bit command words onto the `linked_list` switch interface with a fixed data-setup / command-pulse / idle-gap cadence. It also counts the overflow and underflow flags that come back. On the board it replaces hand-toggled switches for regression runs, and in simulation it replaces hand-written stimulus. Output port `sw_out[15:0]` connects directly to `linked_list.sw`. Input port `flags[1:0]` connects to `linked_list.led`.

## Interface
- `DEPTH`, 16: number of script entries (power of two, at least 2).
- `SETUP_CYCLES`, 4: cycles the data is driven with cmd=000 before the command pulse (at least 1).
- `HOLD_CYCLES`, 10: cycles the command code is held (at least 1).
- `GAP_CYCLES`, 20: cycles of cmd=000 after the pulse, data still held (at least 1).
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level-sampled; begins playback from address 0 when in IDLE or DONE.
- `abort`, in, 1: stops playback; the FSM returns to IDLE on the next edge.
- `load_we`, in, 1: script write strobe; accepted only in IDLE or DONE.
- `load_addr`, in, log2(DEPTH): script write address.
- `load_data`, in, 11: {cmd[2:0], data[7:0]}.
- `flags`, in, 2: [0] overflow, [1] underflow, from `linked_list`.
- `sw_out`, out, 16: {cmd[2:0], 5'b0, data[7:0]}.
- `busy`, out, 1: high in FETCH, SETUP, HOLD, GAP.
- `done`, out, 1: high in DONE.
- `ptr`, out, log2(DEPTH): address of the entry currently being played.
- `ovf_cnt`, `udf_cnt`, out, 8 each: saturating rising-edge counts of flags[0] and flags[1].

## Operation
- Script memory is DEPTH x 11 bits with a synchronous write and a registered read. Memory contents are not reset.
- Command codes: 100 insert head, 101 insert tail, 110 delete value, 111 traverse.
- Code 000 is the end-of-script marker.
- FSM states: IDLE, FETCH, SETUP, HOLD, GAP, DONE.
- IDLE/DONE and `start`: go to FETCH. ptr=0. Both counters cleared.
- FETCH: read memory[ptr] (1 cycle).
  - If cmd=000, go to DONE.
  - Otherwise latch the entry and go to SETUP.
- SETUP: sw_out = {000, 5'b0, data} for SETUP_CYCLES cycles, then HOLD.
- HOLD: sw_out = {cmd, 5'b0, data} for HOLD_CYCLES cycles, then GAP.
- GAP: sw_out = {000, 5'b0, data} for GAP_CYCLES cycles.
  - If ptr = DEPTH-1, go to DONE.
  - Otherwise ptr increments and the FSM goes to FETCH.
- A single down-counter, width log2 of max(SETUP, HOLD, GAP)+1, is reloaded on every state entry.
- Flag edge detect: flags are registered once; a rise is prev=0 and cur=1.
  - Rises are counted in every state except IDLE.
  - Each counter saturates at 255.
- `abort` has priority over everything except reset.
  - Next edge: IDLE, sw_out=0.
  - Counters and ptr are held.
- `start` while busy: ignored.
- `load_we` while busy: ignored, no write.
- `load_we` and `start` in the same cycle: the write completes and playback starts. The FETCH in the following cycle reads the written value.
- DONE holds sw_out=0 until `start`. A `load_we` in DONE is accepted.

## Timing
- Reset values: state=IDLE, sw_out=0, busy=0, done=0, ptr=0, ovf_cnt=0, udf_cnt=0.
- `start` sampled high at edge E gives FETCH after E.
- Data appears on sw_out after E+1.
- The command code appears after E+1+SETUP_CYCLES.
- One non-terminal entry takes 1+SETUP_CYCLES+HOLD_CYCLES+GAP_CYCLES cycles (35 by default).
- An end marker takes 1 cycle (FETCH), then DONE.
- Reset asserted mid-playback clears all outputs asynchronously. Nothing is replayed after release until `start`.

## Configuration
- `LL_SEQ_LOOP_EN`
  - Defined: the end marker, or the end of GAP at ptr=DEPTH-1, returns to FETCH with ptr=0 instead of going to DONE. Counters are not cleared. `done` never asserts; only `abort` or reset stops playback.
  - Undefined: single pass, as described above.

## Test plan
- Reset: assert rst_n=0 mid-GAP -> sw_out=0, busy=0, ptr=0 immediately, both counts 0.
- Script {100/01, 100/03, 101/07, 101/0F, 000}, defaults, start -> four pulses with sw_out[15:13]=100,100,101,101 and data 01,03,07,0F; each pulse exactly 10 cycles; 35 cycles per entry; done 141 cycles after start.
- Same script plus a fifth 100/2F entry, with a 4-node linked_list attached -> exactly one flags[0] rise; ovf_cnt=1.
- Five 110 deletes on an empty list, with flags[1] pulsed on each -> udf_cnt=5. Separately, 300 pulses -> udf_cnt=255, saturated.
- abort during HOLD of entry 2 -> next edge IDLE, sw_out=0, ptr=2 held. A load_we issued during busy leaves the memory unchanged.
- Full 16-entry script with no marker -> DONE after entry 15. With LL_SEQ_LOOP_EN -> ptr wraps to 0 and the pulse for entry 0 repeats.
